// File: rtl/heap_mem_pkg.sv
// rtl/heap_mem_pkg.sv - shared heap memory types and widths
package heap_mem_pkg;

    localparam int HEAP_ADDR_W = 11;
    localparam int HEAP_DATA_W = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector: first request at or after the pointer, wrapping
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W-1:0] w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < N; k++) begin
            // pointer is modulo N, so non-power-of-two counts wrap correctly
            w_pos = IDX_W'((32'(i_ptr) + 32'(k)) % 32'(N));
            if (!o_any && i_req[w_pos]) begin
                o_any   = 1'b1;
                o_idx   = w_pos;
                o_grant = N'(1) << w_pos;
            end
        end
    end

endmodule

// File: rtl/heap_mem_arbiter.sv
// rtl/heap_mem_arbiter.sv - round-robin, burst-locked arbiter sharing heap BRAM port A
module heap_mem_arbiter
    import heap_mem_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = HEAP_ADDR_W,
    parameter int DATA_W    = HEAP_DATA_W,
    parameter int MAX_BURST = 64
) (
    input  logic                           axis_clk,
    input  logic                           axis_reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_last,
    input  logic [NUM_REQ*ADDR_W-1:0]      req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]      req_wr_data,
    input  logic [NUM_REQ*(DATA_W/8)-1:0]  req_wr_en,
    output logic [NUM_REQ-1:0]             rd_valid,
    output logic [DATA_W-1:0]              rd_data,
    output logic                           heap_mem_port_a_clk,
    output logic                           heap_mem_port_a_en,
    output logic [ADDR_W-1:0]              heap_mem_port_a_addr,
    output logic [DATA_W-1:0]              heap_mem_port_a_wr_data,
    output logic [DATA_W/8-1:0]            heap_mem_port_a_wr_en,
    input  logic [DATA_W-1:0]              heap_mem_port_a_rd_data
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_ptr, w_ptr_nxt, r_owner, w_owner_nxt;
    logic [CNT_W-1:0]   r_count, w_count_nxt;
    logic [NUM_REQ-1:0] w_pick_grant;
    logic [IDX_W-1:0]   w_pick_idx, w_sel;
    logic               w_pick_any, w_accept, w_sel_last, w_is_read;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_data;
    logic [BE_W-1:0]    w_sel_be;

    logic               r_en;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wr_data, r_rd_data;
    logic [BE_W-1:0]    r_wr_en;
    logic               r_rd_v1, r_rd_v2;
    logic [IDX_W-1:0]   r_rd_idx1, r_rd_idx2;
    logic [NUM_REQ-1:0] r_rd_valid;

    function automatic logic [IDX_W-1:0] f_wrap(input logic [IDX_W-1:0] idx);
        return (32'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
    endfunction

    rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr_pick (
        .i_req  (req_valid),
        .i_ptr  (r_ptr),
        .o_grant(w_pick_grant),
        .o_idx  (w_pick_idx),
        .o_any  (w_pick_any)
    );

    assign w_sel      = (r_state == IDLE) ? w_pick_idx : r_owner;
    assign w_sel_addr = req_addr[32'(w_sel)*ADDR_W +: ADDR_W];
    assign w_sel_data = req_wr_data[32'(w_sel)*DATA_W +: DATA_W];
    assign w_sel_be   = req_wr_en[32'(w_sel)*BE_W +: BE_W];
    assign w_sel_last = req_last[w_sel];
    assign w_is_read  = (w_sel_be == '0);
    assign w_accept   = |(req_valid & req_ready);

    always_comb begin
        req_ready   = '0;
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_count_nxt = r_count;
        unique case (r_state)
            IDLE: begin
                req_ready = w_pick_grant;
                if (w_pick_any) begin
                    if (w_sel_last || MAX_BURST == 1) begin
                        w_ptr_nxt = f_wrap(w_pick_idx);
                    end else begin
                        w_state_nxt = LOCKED;
                        w_owner_nxt = w_pick_idx;
                        w_count_nxt = CNT_W'(1);
                    end
                end
            end
            LOCKED: begin
                // gaps in the owner's valid keep the lock; nobody else is offered ready
                req_ready[r_owner] = req_valid[r_owner];
                if (req_valid[r_owner]) begin
                    w_count_nxt = r_count + 1'b1;
                    if (w_sel_last || w_count_nxt == CNT_W'(MAX_BURST)) begin
                        w_state_nxt = IDLE;
                        w_ptr_nxt   = f_wrap(r_owner);
                        w_count_nxt = '0;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (axis_reset) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_count    <= '0;
            r_en       <= 1'b0;
            r_addr     <= '0;
            r_wr_data  <= '0;
            r_wr_en    <= '0;
            r_rd_v1    <= 1'b0;
            r_rd_v2    <= 1'b0;
            r_rd_idx1  <= '0;
            r_rd_idx2  <= '0;
            r_rd_valid <= '0;
            r_rd_data  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_count    <= w_count_nxt;
            r_en       <= w_accept;
            r_addr     <= w_accept ? w_sel_addr : '0;
            r_wr_data  <= w_accept ? w_sel_data : '0;
            r_wr_en    <= w_accept ? w_sel_be : '0;
            // BRAM samples the port one edge after acceptance, data is captured one edge later
            r_rd_v1    <= w_accept && w_is_read;
            r_rd_idx1  <= w_sel;
            r_rd_v2    <= r_rd_v1;
            r_rd_idx2  <= r_rd_idx1;
            r_rd_valid <= r_rd_v2 ? (NUM_REQ'(1) << r_rd_idx2) : '0;
            if (r_rd_v2) begin
                r_rd_data <= heap_mem_port_a_rd_data;
            end
        end
    end

    assign heap_mem_port_a_clk     = axis_clk;
    assign heap_mem_port_a_en      = r_en;
    assign heap_mem_port_a_addr    = r_addr;
    assign heap_mem_port_a_wr_data = r_wr_data;
    assign heap_mem_port_a_wr_en   = r_wr_en;
    assign rd_valid                = r_rd_valid;
    assign rd_data                 = r_rd_data;

endmodule
